// File: rtl/matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module  : matrix_pkg
// Brief   : Opcodes and FSM state encoding shared by the matrix feeder.
// Revision: 1.0 - initial release
// ============================================================================
package matrix_pkg;

   localparam logic [7:0] OP_MATRIX = 8'h01;
   localparam logic [7:0] OP_HASH   = 8'h02;

   typedef enum logic [1:0] {
      HDR    = 2'd0,
      M_PASS = 2'd1,
      H_PASS = 2'd2,
      DRAIN  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module  : matrix_feeder
// Brief   : Parses framed host stream and forwards payload to M or hashin FIFO.
//           Define MATRIX_FEEDER_STATS_EN to add per-opcode frame counters.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_feeder
   import matrix_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int LEN_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic              m_full,
   output logic              m_we,
   output logic [DATA_W-1:0] m_wdata,
   input  logic              hashin_full,
   output logic              hashin_we,
   output logic [DATA_W-1:0] hashin_wdata,
   output logic              frame_done,
   output logic              err_len,
   output logic              err_op,
   input  logic              err_clr
`ifdef MATRIX_FEEDER_STATS_EN
   ,
   output logic [15:0]       m_frames,
   output logic [15:0]       h_frames
`endif
);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LEN_W-1:0]   r_cnt;
   logic [LEN_W-1:0]   w_cnt_nxt;
   logic               r_frame_done;
   logic               r_err_len;
   logic               r_err_op;
   logic               w_set_len;
   logic               w_set_op;
   logic               w_done;
   logic               w_full;
   logic               w_acc;

   logic [7:0]         w_op;
   logic [LEN_W-1:0]   w_len;
   logic               w_op_ok;

   assign w_op    = s_data[63:56];
   assign w_len   = s_data[LEN_W-1:0];
   assign w_op_ok = (w_op == OP_MATRIX) || (w_op == OP_HASH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= HDR;
         r_cnt        <= '0;
         r_frame_done <= 1'b0;
         r_err_len    <= 1'b0;
         r_err_op     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_frame_done <= w_done;
         // A new error in the same cycle as err_clr keeps the flag set
         if (w_set_len)    r_err_len <= 1'b1;
         else if (err_clr) r_err_len <= 1'b0;
         if (w_set_op)     r_err_op  <= 1'b1;
         else if (err_clr) r_err_op  <= 1'b0;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      s_ready      = 1'b0;
      m_we         = 1'b0;
      hashin_we    = 1'b0;
      m_wdata      = s_data;
      hashin_wdata = s_data;
      w_set_len    = 1'b0;
      w_set_op     = 1'b0;
      w_done       = 1'b0;
      w_full       = (r_state == M_PASS) ? m_full : hashin_full;
      w_acc        = 1'b0;

      case (r_state)
         HDR: begin
            s_ready = 1'b1;
            if (s_valid) begin
               w_cnt_nxt = w_len;
               if (w_op_ok && (w_len != '0) && !s_last) begin
                  w_state_nxt = (w_op == OP_MATRIX) ? M_PASS : H_PASS;
               end else begin
                  w_set_op    = !w_op_ok;
                  w_set_len   = (w_len == '0) || (w_op_ok && s_last);
                  w_state_nxt = s_last ? HDR : DRAIN;
               end
            end
         end
         M_PASS, H_PASS: begin
            s_ready   = !w_full;
            w_acc     = s_valid && !w_full;
            m_we      = w_acc && (r_state == M_PASS);
            hashin_we = w_acc && (r_state == H_PASS);
            if (w_acc) begin
               w_cnt_nxt = r_cnt - LEN_W'(1);
               if (r_cnt == LEN_W'(1)) begin
                  if (s_last) begin
                     w_done      = 1'b1;
                     w_state_nxt = HDR;
                  end else begin
                     w_set_len   = 1'b1;
                     w_state_nxt = DRAIN;
                  end
               end else if (s_last) begin
                  w_set_len   = 1'b1;
                  w_state_nxt = HDR;
               end
            end
         end
         DRAIN: begin
            s_ready = 1'b1;
            if (s_valid && s_last) w_state_nxt = HDR;
         end
         default: w_state_nxt = HDR;
      endcase
   end

   assign frame_done = r_frame_done;
   assign err_len    = r_err_len;
   assign err_op     = r_err_op;

`ifdef MATRIX_FEEDER_STATS_EN
   logic [15:0] r_m_frames;
   logic [15:0] r_h_frames;

   // Frame kind is known from the pass state at the completing beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m_frames <= '0;
         r_h_frames <= '0;
      end else if (w_done) begin
         if (r_state == M_PASS) r_m_frames <= r_m_frames + 16'd1;
         else                   r_h_frames <= r_h_frames + 16'd1;
      end
   end

   assign m_frames = r_m_frames;
   assign h_frames = r_h_frames;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_matrix_feeder
// Brief   : Scoreboard bench with a frame-level reference model for matrix_feeder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_matrix_feeder;

   localparam int DATA_W = 64;
   localparam int LEN_W  = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [DATA_W-1:0] s_data = '0;
   logic              s_last = 1'b0;
   logic              m_full = 1'b0;
   logic              m_we;
   logic [DATA_W-1:0] m_wdata;
   logic              hashin_full = 1'b0;
   logic              hashin_we;
   logic [DATA_W-1:0] hashin_wdata;
   logic              frame_done;
   logic              err_len;
   logic              err_op;
   logic              err_clr = 1'b0;
`ifdef MATRIX_FEEDER_STATS_EN
   logic [15:0]       m_frames;
   logic [15:0]       h_frames;
`endif

   matrix_feeder #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .s_last       (s_last),
      .m_full       (m_full),
      .m_we         (m_we),
      .m_wdata      (m_wdata),
      .hashin_full  (hashin_full),
      .hashin_we    (hashin_we),
      .hashin_wdata (hashin_wdata),
      .frame_done   (frame_done),
      .err_len      (err_len),
      .err_op       (err_op),
      .err_clr      (err_clr)
`ifdef MATRIX_FEEDER_STATS_EN
      ,
      .m_frames     (m_frames),
      .h_frames     (h_frames)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              hash;
      logic [DATA_W-1:0] data;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  failures = 0;
   int  exp_done = 0;
   int  got_done = 0;
   int  exp_mf = 0;
   int  exp_hf = 0;
   int  hold_hfull = 0;
   bit  exp_err_len = 1'b0;
   bit  exp_err_op = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Scoreboard monitor: every FIFO write must match the oldest expected word
   always @(negedge clk) begin
      wr_t e;
      if (rst_n) begin
         if (m_we || hashin_we) begin
            chk("we_exclusive", 64'(m_we && hashin_we), 64'd0);
            if (m_we)      chk("m_we_while_full", 64'(m_full), 64'd0);
            if (hashin_we) chk("h_we_while_full", 64'(hashin_full), 64'd0);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=m%0b/h%0b required=none", m_we, hashin_we);
            end else begin
               e = exp_q.pop_front();
               chk("wr_target_hash", 64'(hashin_we), 64'(e.hash));
               chk("wr_data", m_we ? m_wdata : hashin_wdata, e.data);
            end
         end
         if (frame_done) got_done++;
      end
   end

   // Holds one beat until the DUT accepts it; acceptance happens on the next rising edge
   task automatic send(input logic [DATA_W-1:0] d, input logic last);
      bit acc = 1'b0;
      int guard = 0;
      while (!acc) begin
         @(posedge clk); #2;
         m_full      = ($urandom_range(0, 3) == 0);
         hashin_full = ($urandom_range(0, 3) == 0);
         if (hold_hfull > 0) begin
            hashin_full = 1'b1;
            hold_hfull--;
         end
         s_valid = ($urandom_range(0, 4) != 0);
         s_data  = d;
         s_last  = last;
         @(negedge clk);
         acc = s_valid && s_ready;
         guard++;
         if (guard > 500) begin
            checks++;
            failures++;
            $display("FAIL beat_accept_timeout actual=%0d required<=500", guard);
            acc = 1'b1;
         end
      end
   endtask

   task automatic idle(input int k);
      @(posedge clk); #2;
      s_valid = 1'b0;
      s_last  = 1'b0;
      m_full  = 1'b0;
      hashin_full = 1'b0;
      repeat (k) @(posedge clk);
      #2;
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_err_len"}, 64'(err_len), 64'(exp_err_len));
      chk({tag, "_err_op"}, 64'(err_op), 64'(exp_err_op));
      chk({tag, "_frame_done_count"}, 64'(got_done), 64'(exp_done));
      chk({tag, "_writes_pending"}, 64'(exp_q.size()), 64'd0);
`ifdef MATRIX_FEEDER_STATS_EN
      chk({tag, "_m_frames"}, 64'(m_frames), 64'(exp_mf[15:0]));
      chk({tag, "_h_frames"}, 64'(h_frames), 64'(exp_hf[15:0]));
`endif
   endtask

   task automatic clear_errors();
      @(posedge clk); #2;
      err_clr = 1'b1;
      @(posedge clk); #2;
      err_clr = 1'b0;
      exp_err_len = 1'b0;
      exp_err_op  = 1'b0;
      chk("after_clr_err_len", 64'(err_len), 64'd0);
      chk("after_clr_err_op", 64'(err_op), 64'd0);
   endtask

   // Reference model works on whole frames: header (op, n), then l payload beats
   task automatic run_frame(input logic [7:0] op, input int n, input bit hdr_last, input int l,
                            input string tag);
      logic [DATA_W-1:0] hdr;
      logic [DATA_W-1:0] d;
      bit ok;
      int nw;
      ok  = ((op == 8'h01) || (op == 8'h02)) && (n != 0);
      hdr = {$urandom, $urandom};
      hdr[63:56] = op;
      hdr[15:0]  = n[15:0];
      if ((op != 8'h01) && (op != 8'h02)) exp_err_op = 1'b1;
      if (n == 0) exp_err_len = 1'b1;
      if (ok && hdr_last) exp_err_len = 1'b1;
      if (ok && !hdr_last) begin
         if (l != n) exp_err_len = 1'b1;
         else begin
            exp_done++;
            if (op == 8'h01) exp_mf++;
            else             exp_hf++;
         end
      end
      nw = (ok && !hdr_last) ? ((l < n) ? l : n) : 0;
      send(hdr, hdr_last);
      if (!hdr_last) begin
         for (int i = 1; i <= l; i++) begin
            d = {$urandom, $urandom};
            if (i <= nw) exp_q.push_back('{hash: (op == 8'h02), data: d});
            send(d, (i == l));
         end
      end
      idle(3);
      check_state(tag);
   endtask

   initial begin
      logic [DATA_W-1:0] hdr;
      logic [DATA_W-1:0] d;
      logic [7:0] ops[6] = '{8'h01, 8'h02, 8'h01, 8'h02, 8'h00, 8'h07};
      int n;
      int l;

      repeat (2) @(posedge clk);
      #2;
      chk("reset_s_ready", 64'(s_ready), 64'd1);
      chk("reset_m_we", 64'(m_we), 64'd0);
      chk("reset_hashin_we", 64'(hashin_we), 64'd0);
      chk("reset_frame_done", 64'(frame_done), 64'd0);
      chk("reset_err_len", 64'(err_len), 64'd0);
      chk("reset_err_op", 64'(err_op), 64'd0);
      rst_n = 1'b1;

      run_frame(8'h01, 3, 1'b0, 3, "matrix_n3");
      hold_hfull = 4;
      run_frame(8'h02, 2, 1'b0, 2, "hash_full_stall");
      run_frame(8'h07, 2, 1'b0, 2, "bad_opcode");
      clear_errors();
      run_frame(8'h01, 4, 1'b0, 2, "short_frame");
      run_frame(8'h01, 2, 1'b0, 2, "after_short");
      clear_errors();
      run_frame(8'h02, 2, 1'b0, 4, "long_frame");
      run_frame(8'h01, 0, 1'b0, 2, "zero_len");
      run_frame(8'h02, 3, 1'b1, 0, "hdr_last");
      clear_errors();

      // err_clr held while a bad-opcode header is accepted: the new error wins
      hdr = {$urandom, $urandom};
      hdr[63:56] = 8'h07;
      hdr[15:0]  = 16'd1;
      err_clr = 1'b1;
      send(hdr, 1'b1);
      @(posedge clk); #2;
      err_clr = 1'b0;
      s_valid = 1'b0;
      exp_err_op = 1'b1;
      idle(2);
      check_state("set_wins");
      clear_errors();

      // Reset mid-frame after the first of three payload beats
      hdr = {$urandom, $urandom};
      hdr[63:56] = 8'h01;
      hdr[15:0]  = 16'd3;
      send(hdr, 1'b0);
      d = {$urandom, $urandom};
      exp_q.push_back('{hash: 1'b0, data: d});
      send(d, 1'b0);
      @(posedge clk); #2;
      rst_n   = 1'b0;
      s_valid = 1'b1;
      s_last  = 1'b0;
      m_full  = 1'b0;
      hashin_full = 1'b0;
      #1;
      chk("rst_mid_m_we", 64'(m_we), 64'd0);
      chk("rst_mid_hashin_we", 64'(hashin_we), 64'd0);
      chk("rst_mid_frame_done", 64'(frame_done), 64'd0);
      chk("rst_mid_err_len", 64'(err_len), 64'd0);
      chk("rst_mid_s_ready", 64'(s_ready), 64'd1);
      @(posedge clk); #2;
      s_valid = 1'b0;
      rst_n   = 1'b1;
      exp_mf = 0;
      exp_hf = 0;
      run_frame(8'h02, 1, 1'b0, 1, "after_reset");
      run_frame(8'h01, 2, 1'b0, 2, "after_reset_m");

      for (int k = 0; k < 40; k++) begin
         n = $urandom_range(0, 4);
         l = ($urandom_range(0, 2) != 0) ? ((n == 0) ? 1 : n) : $urandom_range(1, n + 2);
         run_frame(ops[$urandom_range(0, 5)], n, ($urandom_range(0, 7) == 0), l, "random");
         if ($urandom_range(0, 1) == 1) clear_errors();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
